// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive path.
package uart_pkg;

    localparam int unsigned PACKET_WIDTH = 4;
    localparam int unsigned FRAME_BITS   = 11;
    localparam int unsigned DATA_BITS    = 8;
    localparam logic        START_LEVEL  = 1'b0;
    localparam logic        STOP_LEVEL   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_frame.sv
// Oversampled UART frame receiver: synchronizer, FSM and mid-bit sampler.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk_baud,
    input  logic       rst_n,
    input  logic       uart_stream,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       byte_done_c,
    output logic [7:0] byte_next_c,
    output logic       byte_bad_c,
    output logic       start_c,
    output logic       idle_tick_c
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    logic [1:0]       sync_q;
    logic             rx;
    logic             rx_prev;
    uart_rx_state_t   state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [BIT_W-1:0] bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             par_q, par_n;
    logic             mid_bit;
    logic             perr_c;
    logic             ferr_c;

    assign rx          = sync_q[1];
    assign mid_bit     = (cnt == CNT_W'(OVERSAMPLE - 1));
    assign perr_c      = par_q ^ (^shreg);
    assign ferr_c      = (rx != STOP_LEVEL);
    assign byte_next_c = shreg;
    assign byte_bad_c  = perr_c | ferr_c;

    // Two-stage synchronizer for the asynchronous serial line, plus edge history.
    always_ff @(posedge clk_baud or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], uart_stream};
            rx_prev <= rx;
        end
    end

    // Next-state, tick counter and bit sampling.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CNT_W'(1);
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        par_n       = par_q;
        byte_done_c = 1'b0;
        start_c     = 1'b0;
        idle_tick_c = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (mid_bit) begin
                    cnt_n       = '0;
                    idle_tick_c = 1'b1;
                end
                if (rx_prev != START_LEVEL && rx == START_LEVEL) begin
                    start_c = 1'b1;
                    state_n = ST_START;
                    cnt_n   = '0;
                end
            end
            ST_START: begin
                if (cnt == CNT_W'(OVERSAMPLE / 2 - 1)) begin
                    cnt_n = '0;
                    if (rx == START_LEVEL) begin
                        state_n   = ST_DATA;
                        bit_idx_n = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (mid_bit) begin
                    cnt_n   = '0;
                    shreg_n = {rx, shreg[7:1]};
                    if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                        state_n = ST_PARITY;
                    end else begin
                        bit_idx_n = bit_idx + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (mid_bit) begin
                    cnt_n   = '0;
                    par_n   = rx;
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (mid_bit) begin
                    cnt_n       = '0;
                    byte_done_c = 1'b1;
                    state_n     = ferr_c ? ST_WAIT_HIGH : ST_IDLE;
                end
            end
            ST_WAIT_HIGH: begin
                cnt_n = '0;
                if (rx == STOP_LEVEL) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State register and registered byte outputs.
    always_ff @(posedge clk_baud or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_q      <= 1'b0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            par_q      <= par_n;
            byte_valid <= byte_done_c;
            if (byte_done_c) begin
                byte_data  <= shreg;
                parity_err <= perr_c;
                frame_err  <= ferr_c;
            end
        end
    end

endmodule

// File: rtl/uart_decode.sv
// UART receiver with packet assembly and idle-timeout discard of partial packets.
module uart_decode #(
    parameter int unsigned PACKET_WIDTH = uart_pkg::PACKET_WIDTH,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned IDLE_TIMEOUT = 2
) (
    input  logic                         clk_baud,
    input  logic                         rst_n,
    input  logic                         uart_stream,
    output logic [PACKET_WIDTH-1:0][7:0] sys_packet,
    output logic                         packet_valid,
    output logic                         packet_err,
    output logic [7:0]                   byte_data,
    output logic                         byte_valid,
    output logic                         parity_err,
    output logic                         frame_err
);

    localparam int unsigned IDX_W = (PACKET_WIDTH > 1) ? $clog2(PACKET_WIDTH) : 1;
    localparam int unsigned IT_W  = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    logic                         byte_done_c;
    logic [7:0]                   byte_next_c;
    logic                         byte_bad_c;
    logic                         start_c;
    logic                         idle_tick_c;
    logic                         pkt_done_c;
    logic                         timeout_c;

    logic [PACKET_WIDTH-1:0][7:0] shadow, shadow_n;
    logic [IDX_W-1:0]             idx, idx_n;
    logic                         sticky, sticky_n;
    logic [IT_W-1:0]              idle_cnt, idle_cnt_n;

    uart_rx_frame #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_frame (
        .clk_baud    (clk_baud),
        .rst_n       (rst_n),
        .uart_stream (uart_stream),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .byte_done_c (byte_done_c),
        .byte_next_c (byte_next_c),
        .byte_bad_c  (byte_bad_c),
        .start_c     (start_c),
        .idle_tick_c (idle_tick_c)
    );

    assign timeout_c = (idle_cnt == IT_W'(IDLE_TIMEOUT)) && (idx != '0);

    // Slot index, sticky error and idle bit-time counter update.
    always_comb begin
        shadow_n   = shadow;
        idx_n      = idx;
        sticky_n   = sticky;
        idle_cnt_n = idle_cnt;
        pkt_done_c = 1'b0;
        if (start_c) begin
            idle_cnt_n = '0;
        end else if (idle_tick_c && idle_cnt != IT_W'(IDLE_TIMEOUT)) begin
            idle_cnt_n = idle_cnt + IT_W'(1);
        end
        if (byte_done_c) begin
            shadow_n[idx] = byte_next_c;
            if (idx == IDX_W'(PACKET_WIDTH - 1)) begin
                pkt_done_c = 1'b1;
                idx_n      = '0;
                sticky_n   = 1'b0;
            end else begin
                idx_n    = idx + IDX_W'(1);
                sticky_n = sticky | byte_bad_c;
            end
        end else if (timeout_c) begin
            idx_n    = '0;
            sticky_n = 1'b0;
        end
    end

    // Assembly state and registered packet outputs.
    always_ff @(posedge clk_baud or negedge rst_n) begin
        if (!rst_n) begin
            shadow       <= '0;
            idx          <= '0;
            sticky       <= 1'b0;
            idle_cnt     <= '0;
            sys_packet   <= '0;
            packet_valid <= 1'b0;
            packet_err   <= 1'b0;
        end else begin
            shadow       <= shadow_n;
            idx          <= idx_n;
            sticky       <= sticky_n;
            idle_cnt     <= idle_cnt_n;
            packet_valid <= pkt_done_c;
            if (pkt_done_c) begin
                sys_packet <= shadow_n;
                packet_err <= sticky | byte_bad_c;
            end
        end
    end

endmodule

// File: doc/uart_decode.md
# uart_decode

Receive-side counterpart of the packet UART encoder. Oversamples the incoming serial line, recovers 11-bit frames (start, 8 data LSB-first, even parity, stop) and checks parity and stop bit. Assembles PACKET_WIDTH consecutive bytes into a packet and presents it with a one-cycle valid strobe to downstream packet logic.

## Interface
Parameters:
- PACKET_WIDTH, default uart_pkg::PACKET_WIDTH (4): bytes per packet.
- OVERSAMPLE, default 16: clk_baud cycles per bit; must be even and ≥4.
- IDLE_TIMEOUT, default 2: idle bit-times between bytes after which a partial packet is discarded.

Ports:
- clk_baud  in  1  sample clock, OVERSAMPLE × bit rate.
- rst_n  in  1  reset.
- uart_stream  in  1  serial line, idle high, asynchronous to clk_baud.
- sys_packet  out  [PACKET_WIDTH-1:0][7:0]  last complete packet; byte 0 = first received.
- packet_valid  out  1  one-cycle strobe: sys_packet updated.
- packet_err  out  1  valid with packet_valid: some byte in packet had parity or frame error.
- byte_data  out  8  last received byte.
- byte_valid  out  1  one-cycle strobe per received frame.
- parity_err  out  1  valid with byte_valid: received parity ≠ ^byte_data.
- frame_err  out  1  valid with byte_valid: stop bit sampled 0.

One clock, clk_baud. Reset rst_n is asynchronous, active-low.

## Operation
- uart_stream passes through a 2-FF synchronizer (reset to 1); all logic uses the synchronized line `rx`.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: on `rx` = 0 (previous 1), go to START and clear the tick counter.
- START: at tick OVERSAMPLE/2−1, sample `rx`. If 1, treat as a glitch and return to IDLE with no output. If 0, go to DATA and restart the counter.
- DATA: sample every OVERSAMPLE ticks, at mid-bit. Shift into bit position 0..7, LSB first. After bit 7, go to PARITY.
- PARITY: sample one bit, then go to STOP.
- STOP: sample one bit and pulse byte_valid.
  - Stop = 1: return to IDLE.
  - Stop = 0: set frame_err and go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx` = 1, then go to IDLE. A falling edge is not accepted until the line has been seen high.
- Byte assembly:
  - Each byte_valid writes byte_data into slot `idx` of a shadow buffer and ORs its errors into a sticky error flag.
  - When `idx` = PACKET_WIDTH−1: copy the shadow buffer to sys_packet, pulse packet_valid, drive packet_err from the sticky flag, then clear `idx` and the sticky flag. Otherwise `idx` increments.
- Timeout: an idle counter runs in IDLE and counts bit-times.
  - When it reaches IDLE_TIMEOUT with `idx` ≠ 0, clear `idx` and the sticky flag. The partial packet is dropped silently.
  - A falling edge clears the idle counter.
- Erroneous bytes still occupy a packet slot; they are not dropped.

## Timing
- Reset values:
  - sys_packet = 0, byte_data = 0.
  - All strobes and error flags = 0.
  - FSM in IDLE; `idx`, counters and sticky flag = 0.
- Latency: byte_valid asserts on the cycle after the stop-bit mid sample. That is 2 (sync) + OVERSAMPLE/2 + 10·OVERSAMPLE cycles after the falling edge reaches uart_stream, ±1.
- packet_valid coincides with the last byte's byte_valid.
- byte_data, parity_err and frame_err hold until the next byte_valid.
- sys_packet and packet_err hold until the next packet_valid.
- No back-pressure: downstream must capture on the strobe.
- Back-to-back frames: a start bit arriving immediately after the stop-bit mid sample is accepted. From STOP, the next falling edge is detected in IDLE from the following cycle.
- Timeout and byte_valid in the same cycle cannot occur; timeout is evaluated only in IDLE.
- Reset mid-frame: everything returns to reset values immediately, and the partial byte and packet are lost.

## Structure
- Package uart_pkg holds:
  - PACKET_WIDTH default;
  - frame constants: FRAME_BITS = 11, DATA_BITS = 8, START_LEVEL = 0, STOP_LEVEL = 1;
  - the rx state enum `uart_rx_state_t`.
- Sub-module `uart_rx_frame`: synchronizer, FSM and bit sampler, producing byte_data, byte_valid, parity_err and frame_err, plus an idle bit-tick output.
- uart_decode itself wraps `uart_rx_frame` and adds packet assembly and the timeout.

## Test plan
All scenarios use OVERSAMPLE = 16 and PACKET_WIDTH = 4.
- Send bytes 0x55, 0xA3, 0x00, 0xFF with correct parity, back-to-back → 4 byte_valid strobes; packet_valid once; sys_packet = {0xFF, 0x00, 0xA3, 0x55}; packet_err = 0.
- Send 0x3C with parity bit 1 (wrong) → byte_valid with parity_err = 1. After 3 more good bytes, packet_err = 1.
- Send 0x81 with stop bit 0, holding the line low for 3 bit-times, then a good byte 0x12 → frame_err = 1 on the first byte. No spurious frame while the line is low. 0x12 is received cleanly.
- Drive a 0 pulse 5 cycles wide on an idle line → no byte_valid; FSM back in IDLE.
- Send 2 good bytes, idle 3 bit-times, then send 4 bytes 0x01..0x04 → a single packet_valid with sys_packet = {0x04, 0x03, 0x02, 0x01}.
- Assert rst_n low in the middle of the DATA bits of byte 2 → all outputs 0 immediately. A following 4-byte packet is received correctly, starting at slot 0.
